vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates 640x480 @ 60 Hz VGA raster timing from the pixel clock.
- Produces horizontal and vertical counters (DrawX/DrawY), active-low syncs, an active-video flag (blank), and frame/line strobes.
- Directly upstream of every sprite/background renderer, which consumes DrawX, DrawY and blank on the same vga_clk.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- vga_clk  input  1  pixel clock (25 MHz nominal)
- reset  input  1  asynchronous, active-high
- DrawX  output  10  horizontal counter, 0..H_TOTAL-1
- DrawY  output  10  vertical counter, 0..V_TOTAL-1
- hs  output  1  horizontal sync, active-low
- vs  output  1  vertical sync, active-low
- blank  output  1  1 = active video (DrawX<H_VISIBLE and DrawY<V_VISIBLE); 0 = blanking
- line_start  output  1  one-cycle pulse when DrawX==0
- frame_start  output  1  one-cycle pulse when DrawX==0 and DrawY==0
- frame_count  output  8  frames started since reset, wraps

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the H_* parameters (800 with defaults).
  - V_TOTAL = sum of the V_* parameters (525 with defaults).
- Reset state (async assert; all outputs are flops):
  - DrawX = H_TOTAL-1 (799), DrawY = V_TOTAL-1 (524).
  - hs = 1, vs = 1, blank = 0.
  - line_start = 0, frame_start = 0, frame_count = 0.
- Reset is held asynchronously for its full duration. The first vga_clk rising edge after deassertion advances to (0,0).
- Counter update on each rising edge:
  - DrawX increments.
  - When DrawX == H_TOTAL-1: DrawX -> 0 and DrawY increments.
  - When DrawY == V_TOTAL-1 at the same time: DrawY -> 0.
- Zero relative latency: hs, vs, blank, line_start and frame_start are registered from next-state counter values, so in any cycle they describe the DrawX/DrawY values presented in that same cycle.
- hs = 0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC, i.e. DrawX in 656..751 with defaults.
- vs = 0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC, i.e. DrawY in 490..491. vs depends only on DrawY, so it changes only in the DrawX==0 cycle.
- blank = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
- line_start: high for exactly one cycle per line, in the DrawX==0 cycle.
- frame_start: high in the (0,0) cycle only.
- frame_count:
  - Increments by 1 in the same edge that moves the counters to (0,0), so it reads 1 during the first frame after reset.
  - 8-bit wrap: 255 -> 0.
- Frame period: H_TOTAL*V_TOTAL = 420000 clocks.
- Reset mid-frame: all outputs return immediately (asynchronously) to reset values. The raster restarts at (0,0) on the first edge after release, and frame_count restarts at 1.
- No pixel data path. Downstream renderers register RGB from DrawX/DrawY/blank on the same vga_clk, adding one pixel of latency relative to hs/vs. This is an accepted system-level skew and must not be compensated here.

Test Plan:
- Reset release: assert reset mid-run, check outputs at the reset values (799, 524, hs=1, vs=1, blank=0, count 0). Release, then on the first edge require DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, frame_count=1.
- Horizontal timing on line 0:
  - blank=1 for DrawX 0..639 and falls at DrawX=640.
  - hs falls at DrawX=656 and rises at DrawX=752, giving 96 low cycles.
  - DrawX wraps 799 -> 0 with DrawY 0 -> 1, and line_start pulses exactly once per 800 clocks.
- Vertical timing:
  - blank stays 0 for all of DrawY 480..524.
  - vs is low exactly for DrawY 490 and 491 (1600 clocks), with edges only in DrawX==0 cycles.
- Frame wrap:
  - (799,524) -> (0,0) with frame_start=1.
  - Consecutive frame_start pulses are exactly 420000 clocks apart.
  - After 256 frames, frame_count has wrapped from 255 to 0.
- Reset mid-operation: assert reset asynchronously at (300,200) between clock edges. Outputs change before the next edge, and after release the raster restarts at (0,0) with frame_count=1.
- Parameter override (H_VISIBLE=320, H_FP=8, H_SYNC=48, H_BP=24, V defaults):
  - Line period is 400 clocks.
  - hs is low for DrawX 328..375.
  - blank falls at DrawX=320.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: counters, syncs, blank and strobes.
// Every output is a flop so renderers see glitch-free timing.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS = 10'(H_VISIBLE);
  localparam logic [9:0] Y_VIS = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_HI = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_LO = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_HI = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       ls_q, ls_d;
  logic       fs_q, fs_d;
  logic [7:0] fc_q, fc_d;

  // Flags decode the next position so they line up with the counters.
  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == X_MAX) begin
      x_d = '0;
      y_d = (y_q == Y_MAX) ? '0 : y_q + 10'd1;
    end
    hs_d    = !((x_d >= HS_LO) && (x_d < HS_HI));
    vs_d    = !((y_d >= VS_LO) && (y_d < VS_HI));
    blank_d = (x_d < X_VIS) && (y_d < Y_VIS);
    ls_d    = (x_d == '0);
    fs_d    = (x_d == '0) && (y_d == '0);
    fc_d    = fs_d ? fc_q + 8'd1 : fc_q;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      x_q     <= X_MAX;
      y_q     <= Y_MAX;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule
